// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one MFA/MFC 4-phase memory bus between instruction
// fetch (port 0) and data load/store (port 1) with round-robin on contention.
// Address, write data, READ_WRITE and WORD_BYTE are muxed to memory from the
// registered GRANT; MFC and read data are routed back to the owner.
// Optional feature: define BUS_TIMEOUT_EN to add a BUSY-cycle watchdog that
// completes a hung transfer with BUS_ERR set after TMO_CYC cycles.
module mem_bus_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TMO_CYC = 255
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic [1:0]      MFA,
  input  logic [1:0]      READ_WRITE,
  input  logic [1:0]      WORD_BYTE,
  input  logic [2*AW-1:0] ADDR,
  input  logic [2*DW-1:0] WDATA,
  output logic [1:0]      MFC,
  output logic [DW-1:0]   RDATA,
  output logic [1:0]      GRANT,
  output logic            BUS_ERR,
  output logic            mem_mfa,
  output logic            mem_rw,
  output logic            mem_wb,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata,
  input  logic            mem_mfc
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_REL  = 2'd2
  } state_t;

  // The watchdog counter is 8 bits wide, so the limit must fit in it.
  if (TMO_CYC < 1 || TMO_CYC > 255) begin : g_tmo_range
    $error("mem_bus_arbiter: TMO_CYC must be in 1..255");
  end

  state_t        state_q;
  logic [1:0]    grant_q;
  logic [1:0]    mfc_q;
  logic          last_owner_q;
  logic [DW-1:0] rdata_q;
  logic          mem_mfa_q;

  logic          owner;
  logic [1:0]    owner_oh;
  logic          pick_d;

  // Owner index comes from the registered grant; idle (00) selects port 0.
  assign owner    = grant_q[1];
  assign owner_oh = owner ? 2'b10 : 2'b01;

  // Winner for the next grant: a lone requester wins, a tie goes to the
  // port that did not own the bus last.
  always_comb begin
    pick_d = MFA[1];
    if (MFA == 2'b11) begin
      pick_d = ~last_owner_q;
    end
  end

  // Bus muxes follow GRANT only, never the raw request lines.
  assign mem_addr  = owner ? ADDR[2*AW-1:AW]  : ADDR[AW-1:0];
  assign mem_wdata = owner ? WDATA[2*DW-1:DW] : WDATA[DW-1:0];
  assign mem_rw    = READ_WRITE[owner];
  assign mem_wb    = WORD_BYTE[owner];

  assign MFC     = mfc_q;
  assign GRANT   = grant_q;
  assign RDATA   = rdata_q;
  assign mem_mfa = mem_mfa_q;

`ifdef BUS_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TMO_CYC - 1);

  logic [7:0] tmo_q;
  logic       bus_err_q;

  assign BUS_ERR = bus_err_q;
`else
  assign BUS_ERR = 1'b0;
`endif

  // Arbitration FSM: IDLE grants, BUSY waits for memory, RELEASE waits for
  // the owner and memory to both drop their handshake lines.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= S_IDLE;
      grant_q      <= 2'b00;
      mfc_q        <= 2'b00;
      last_owner_q <= 1'b1;
      rdata_q      <= '0;
      mem_mfa_q    <= 1'b0;
`ifdef BUS_TIMEOUT_EN
      tmo_q        <= 8'd0;
      bus_err_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (|MFA) begin
            grant_q   <= pick_d ? 2'b10 : 2'b01;
            mem_mfa_q <= 1'b1;
            state_q   <= S_BUSY;
`ifdef BUS_TIMEOUT_EN
            tmo_q     <= 8'd0;
`endif
          end
        end
        S_BUSY: begin
`ifdef BUS_TIMEOUT_EN
          tmo_q <= tmo_q + 8'd1;
`endif
          if (mem_mfc) begin
            if (READ_WRITE[owner]) begin
              rdata_q <= mem_rdata;
            end
            mfc_q     <= owner_oh;
            mem_mfa_q <= 1'b0;
            state_q   <= S_REL;
          end
`ifdef BUS_TIMEOUT_EN
          else if (tmo_q == TMO_LAST) begin
            bus_err_q <= 1'b1;
            mfc_q     <= owner_oh;
            mem_mfa_q <= 1'b0;
            state_q   <= S_REL;
          end
`endif
        end
        S_REL: begin
          if (!MFA[owner] && !mem_mfc) begin
            mfc_q        <= 2'b00;
            last_owner_q <= owner;
            grant_q      <= 2'b00;
            state_q      <= S_IDLE;
`ifdef BUS_TIMEOUT_EN
            bus_err_q    <= 1'b0;
`endif
          end
        end
        default: begin
          grant_q   <= 2'b00;
          mfc_q     <= 2'b00;
          mem_mfa_q <= 1'b0;
          state_q   <= S_IDLE;
        end
      endcase
    end
  end

endmodule
